// File: rtl/rmon_counter_update.sv
// rmon_counter_update
// Port-A read-modify-write engine for the RMON statistics RAM. After reset it
// zero-fills every counter. It then serves TX/RX increment requests with
// round-robin arbitration. Each update takes four cycles:
// grant -> read -> capture sum -> write.
// All outputs are registered. They are loaded on the edge that enters the state
// they belong to, so the READ address and acknowledge are visible one cycle
// after the grant, and the write one cycle after the sum is formed.
module rmon_counter_update #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int INC_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Reg_apply_0,
    input  logic [ADDR_WIDTH-1:0] Reg_addr_0,
    input  logic [INC_WIDTH-1:0]  Reg_data_0,
    output logic                  Reg_next_0,
    input  logic                  Reg_apply_1,
    input  logic [ADDR_WIDTH-1:0] Reg_addr_1,
    input  logic [INC_WIDTH-1:0]  Reg_data_1,
    output logic                  Reg_next_1,
    output logic [ADDR_WIDTH-1:0] Addra,
    output logic [DATA_WIDTH-1:0] Dina,
    output logic                  Wea,
    input  logic [DATA_WIDTH-1:0] Douta,
    output logic                  Init_done
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   init_cnt_reg, init_cnt_next;
    logic                    ptr_reg, ptr_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [INC_WIDTH-1:0]    inc_reg, inc_next;
    logic [ADDR_WIDTH-1:0]   addra_reg, addra_next;
    logic [DATA_WIDTH-1:0]   dina_reg, dina_next;
    logic                    wea_reg, wea_next;
    logic [1:0]              ack_reg, ack_next;
    logic                    init_done_reg, init_done_next;
    logic                    sel;

    // Channel requests gathered into vectors so one arbiter serves both.
    logic [1:0]              req;
    logic [ADDR_WIDTH-1:0]   ch_addr [2];
    logic [INC_WIDTH-1:0]    ch_inc  [2];

    assign req        = {Reg_apply_1, Reg_apply_0};
    assign ch_addr[0] = Reg_addr_0;
    assign ch_addr[1] = Reg_addr_1;
    assign ch_inc[0]  = Reg_data_0;
    assign ch_inc[1]  = Reg_data_1;

    assign Addra      = addra_reg;
    assign Dina       = dina_reg;
    assign Wea        = wea_reg;
    assign Reg_next_0 = ack_reg[0];
    assign Reg_next_1 = ack_reg[1];
    assign Init_done  = init_done_reg;

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        ptr_next       = ptr_reg;
        addr_next      = addr_reg;
        inc_next       = inc_reg;
        addra_next     = addra_reg;
        dina_next      = dina_reg;
        wea_next       = 1'b0;
        ack_next       = 2'b00;
        init_done_next = init_done_reg;
        sel            = 1'b0;

        case (state_reg)
            ST_INIT: begin
                wea_next      = 1'b1;
                dina_next     = '0;
                addra_next    = init_cnt_reg;
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                init_done_next = 1'b1;
                if (req != 2'b00) begin
                    // The pointer only moves when there is a real contention.
                    if (req == 2'b11) begin
                        sel      = ptr_reg;
                        ptr_next = ~ptr_reg;
                    end else begin
                        sel = req[1];
                    end
                    addr_next     = ch_addr[sel];
                    inc_next      = ch_inc[sel];
                    addra_next    = ch_addr[sel];
                    ack_next[sel] = 1'b1;
                    state_next    = ST_READ;
                end
            end
            ST_READ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Douta now holds the counter addressed during READ.
                dina_next  = Douta + DATA_WIDTH'(inc_reg);
                addra_next = addr_reg;
                wea_next   = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight update.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            ptr_reg       <= 1'b0;
            addr_reg      <= '0;
            inc_reg       <= '0;
            addra_reg     <= '0;
            dina_reg      <= '0;
            wea_reg       <= 1'b0;
            ack_reg       <= 2'b00;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            ptr_reg       <= ptr_next;
            addr_reg      <= addr_next;
            inc_reg       <= inc_next;
            addra_reg     <= addra_next;
            dina_reg      <= dina_next;
            wea_reg       <= wea_next;
            ack_reg       <= ack_next;
            init_done_reg <= init_done_next;
        end
    end

endmodule

// File: tb/tb_rmon_counter_update.sv
// Directed testbench for rmon_counter_update. It includes a behavioural
// dual-port RAM whose port A is driven by the DUT. The bench reads the RAM
// contents directly in place of port B. It can also preload a word.
module tb_rmon_counter_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        apply0 = 1'b0, apply1 = 1'b0;
    logic [5:0]  addr0 = '0, addr1 = '0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        next0, next1;
    logic [5:0]  addra;
    logic [31:0] dina;
    logic        wea;
    logic [31:0] douta;
    logic        init_done;

    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] ram [64];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    rmon_counter_update dut (
        .Clk(clk), .Reset(rst),
        .Reg_apply_0(apply0), .Reg_addr_0(addr0), .Reg_data_0(data0), .Reg_next_0(next0),
        .Reg_apply_1(apply1), .Reg_addr_1(addr1), .Reg_data_1(data1), .Reg_next_1(next1),
        .Addra(addra), .Dina(dina), .Wea(wea), .Douta(douta), .Init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM model; bench preload takes priority over port A.
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (wea) ram[addra] <= dina;
        douta <= ram[addra];
    end

    task automatic test_reset();
        int seq_err = 0;
        int rise = 0;
        int nz = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({addra, dina, wea, next0, next1, init_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addra=%0h dina=%0h wea=%b next=%b%b init_done=%b, required all 0",
                     addra, dina, wea, next1, next0, init_done);
        end
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k <= 64) begin
                if (wea !== 1'b1 || addra !== 6'(k - 1) || dina !== 32'h0) seq_err++;
            end else if (wea !== 1'b0) seq_err++;
            if (init_done === 1'b1 && rise == 0) rise = k;
            if (next0 !== 1'b0 || next1 !== 1'b0) seq_err++;
        end
        $display("test_reset: zero-fill observed, Init_done rose at cycle %0d", rise);
        n_checks++;
        if (seq_err !== 0) begin
            n_fail++;
            $display("FAIL zero_fill_sequence: %0d bad cycles, required 0", seq_err);
        end
        n_checks++;
        if (rise !== 65) begin
            n_fail++;
            $display("FAIL init_done_rise: cycle %0d, required 65", rise);
        end
        for (int a = 0; a < 64; a++) if (ram[a] !== 32'h0) nz++;
        n_checks++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL ram_zeroed: %0d nonzero words, required 0", nz);
        end
    endtask

    task automatic test_single();
        int t = 0;
        int c1, c2;
        @(negedge clk);
        apply0 = 1'b1; addr0 = 6'd5; data0 = 16'd3;
        while (next0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        c1 = cyc;
        $display("test_single: first ack after %0d cycles", t);
        n_checks++;
        if (t !== 1 || next1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack1: latency %0d next1=%b, required 1 and 0", t, next1);
        end
        n_checks++;
        if (addra !== 6'd5 || wea !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read: addra=%0d wea=%b, required 5 and 0", addra, wea);
        end
        @(negedge clk);
        n_checks++;
        if (next0 !== 1'b0 || wea !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: next0=%b wea=%b in WAIT, required 0 and 0", next0, wea);
        end
        @(negedge clk);
        n_checks++;
        if (wea !== 1'b1 || addra !== 6'd5 || dina !== 32'd3) begin
            n_fail++;
            $display("FAIL single_write: wea=%b addra=%0d dina=%0h, required 1, 5, 3", wea, addra, dina);
        end
        @(negedge clk);
        n_checks++;
        if (ram[5] !== 32'd3 || wea !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ram1: ram[5]=%0h wea=%b, required 3 and 0", ram[5], wea);
        end
        t = 0;
        while (next0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        c2 = cyc;
        apply0 = 1'b0;
        n_checks++;
        if (next0 !== 1'b1 || (c2 - c1) !== 4) begin
            n_fail++;
            $display("FAIL single_spacing: next0=%b spacing %0d, required 1 and 4", next0, c2 - c1);
        end
        repeat (3) @(negedge clk);
        $display("test_single: ram[5]=%0h", ram[5]);
        n_checks++;
        if (ram[5] !== 32'd6) begin
            n_fail++;
            $display("FAIL single_ram2: ram[5]=%0h, required 6", ram[5]);
        end
    endtask

    task automatic test_wrap();
        int t = 0;
        @(negedge clk);
        pre_en = 1'b1; pre_addr = 6'd9; pre_data = 32'hFFFF_FFFE;
        @(negedge clk);
        pre_en = 1'b0;
        apply1 = 1'b1; addr1 = 6'd9; data1 = 16'd5;
        while (next1 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        apply1 = 1'b0;
        n_checks++;
        if (next1 !== 1'b1 || next0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ack: next1=%b next0=%b, required 1 and 0", next1, next0);
        end
        repeat (3) @(negedge clk);
        $display("test_wrap: ram[9]=%0h", ram[9]);
        n_checks++;
        if (ram[9] !== 32'h0000_0003) begin
            n_fail++;
            $display("FAIL wrap_sum: ram[9]=%0h, required 3", ram[9]);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0, order_err = 0, space_err = 0, both_err = 0;
        int last = 0, t = 0;
        int ch;
        @(negedge clk);
        apply0 = 1'b1; addr0 = 6'd1; data0 = 16'd1;
        apply1 = 1'b1; addr1 = 6'd2; data1 = 16'd1;
        while (acks < 8 && t < 80) begin
            @(negedge clk);
            t++;
            if (next0 === 1'b1 && next1 === 1'b1) both_err++;
            else if (next0 === 1'b1 || next1 === 1'b1) begin
                ch = (next1 === 1'b1) ? 1 : 0;
                $display("test_back_to_back: ack %0d to channel %0d at cycle %0d", acks, ch, cyc);
                if (ch != (acks % 2)) order_err++;
                if (acks > 0 && (cyc - last) != 4) space_err++;
                last = cyc;
                acks++;
                if (acks == 8) begin apply0 = 1'b0; apply1 = 1'b0; end
            end
        end
        apply0 = 1'b0; apply1 = 1'b0;
        n_checks++;
        if (acks !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: %0d acks, required 8", acks);
        end
        n_checks++;
        if (order_err !== 0 || both_err !== 0) begin
            n_fail++;
            $display("FAIL b2b_order: %0d order errors %0d double acks, required 0 and 0", order_err, both_err);
        end
        n_checks++;
        if (space_err !== 0) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d errors, required 0", space_err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ram[1] !== 32'd4 || ram[2] !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_ram: ram[1]=%0h ram[2]=%0h, required 4 and 4", ram[1], ram[2]);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0, seq_err = 0, bad = 0;
        @(negedge clk);
        apply0 = 1'b1; addr0 = 6'd7; data0 = 16'd9;
        while (next0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        apply0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wea !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_wea: wea=%b in WAIT, required 0", wea);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wea !== 1'b0 || next0 !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: wea=%b next0=%b init_done=%b, required 0 0 0", wea, next0, init_done);
        end
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k <= 64 && (wea !== 1'b1 || addra !== 6'(k - 1))) seq_err++;
            if (wea === 1'b1 && dina !== 32'h0) bad++;
            if (next0 !== 1'b0 || next1 !== 1'b0) bad++;
        end
        $display("test_reset_mid: refill done, ram[7]=%0h", ram[7]);
        n_checks++;
        if (seq_err !== 0) begin
            n_fail++;
            $display("FAIL mid_refill: %0d bad cycles, required 0", seq_err);
        end
        n_checks++;
        if (bad !== 0 || ram[7] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_discard: %0d stray events ram[7]=%0h, required 0 and 0", bad, ram[7]);
        end
    endtask

    task automatic test_init_requests();
        int t = 0, early = 0;
        rst = 1'b1;
        @(negedge clk);
        apply0 = 1'b1; addr0 = 6'd10; data0 = 16'd1;
        apply1 = 1'b1; addr1 = 6'd11; data1 = 16'd2;
        rst = 1'b0;
        while (next0 !== 1'b1 && next1 !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
            if ((next0 === 1'b1 || next1 === 1'b1) && init_done !== 1'b1) early++;
        end
        $display("test_init_requests: first ack at cycle %0d after reset release", t);
        n_checks++;
        if (early !== 0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_no_early_ack: %0d early init_done=%b, required 0 and 1", early, init_done);
        end
        n_checks++;
        if (next0 !== 1'b1 || next1 !== 1'b0) begin
            n_fail++;
            $display("FAIL init_first_grant: next0=%b next1=%b, required 1 and 0", next0, next1);
        end
        apply0 = 1'b0;
        t = 0;
        while (next1 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        apply1 = 1'b0;
        n_checks++;
        if (next1 !== 1'b1 || t !== 4) begin
            n_fail++;
            $display("FAIL init_second_grant: next1=%b after %0d cycles, required 1 after 4", next1, t);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ram[10] !== 32'd1 || ram[11] !== 32'd2) begin
            n_fail++;
            $display("FAIL init_ram: ram[10]=%0h ram[11]=%0h, required 1 and 2", ram[10], ram[11]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_init_requests();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rmon_counter_update.md
# rmon_counter_update

Read-modify-write engine that drives port A of the RMON statistics dual-port RAM. It accepts counter-increment requests from the TX and RX statistics collectors, arbitrates them round-robin, reads the current 32-bit counter, adds the increment and writes the result back. After reset it zero-fills the whole RAM before accepting any requests, so the CPU on port B always sees defined counter values.

## Interface
- ADDR_WIDTH, 6: counter address width; RAM depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 32: counter width.
- INC_WIDTH, 16: increment width; zero-extended to DATA_WIDTH before the add.
- Clk  input  1  single clock for the block and RAM port A.
- Reset  input  1  asynchronous, active-high.
- Reg_apply_0  input  1  channel 0 (TX) request; level, held until Reg_next_0.
- Reg_addr_0  input  ADDR_WIDTH  channel 0 counter address; stable while Reg_apply_0 is high.
- Reg_data_0  input  INC_WIDTH  channel 0 increment; stable while Reg_apply_0 is high.
- Reg_next_0  output  1  channel 0 acknowledge; one-cycle pulse.
- Reg_apply_1, Reg_addr_1, Reg_data_1, Reg_next_1: channel 1 (RX); same widths and rules as channel 0.
- Addra  output  ADDR_WIDTH  RAM port A address.
- Dina  output  DATA_WIDTH  RAM port A write data.
- Wea  output  1  RAM port A write enable.
- Douta  input  DATA_WIDTH  RAM port A read data; valid one cycle after Addra is sampled.
- Init_done  output  1  high once the zero-fill is complete; stays high until Reset.

## Operation
- All outputs are registered. Reset values: Addra=0, Dina=0, Wea=0, Reg_next_0=0, Reg_next_1=0, Init_done=0.
- Reset also clears state to INIT, sets the init counter to 0 and sets the round-robin pointer to channel 0.
- INIT:
  - Each cycle drives Wea=1, Dina=0, Addra=init counter, then increments the counter.
  - After address 2^ADDR_WIDTH-1 is written, goes to IDLE and sets Init_done=1.
  - Requests are ignored during INIT and no acknowledges are issued.
- IDLE:
  - With no Reg_apply asserted, stays in IDLE with Wea=0.
  - With one channel requesting, grants it.
  - With both requesting, grants the channel selected by the pointer; the pointer then moves to the other channel.
  - A single requester never changes the pointer.
  - On grant, latches the address and increment and goes to READ.
- READ: Addra=latched address, Wea=0, Reg_next_x=1 for the granted channel only. Goes to WAIT.
- WAIT: Douta becomes valid. Registers sum = Douta + zero-extended increment, modulo 2^DATA_WIDTH (wraps, no saturation). Goes to WRITE.
- WRITE: Addra=latched address, Dina=sum, Wea=1. Goes to IDLE.
- Requesters must drop Reg_apply_x, or present a new address and increment, in the cycle after Reg_next_x is seen high.
- An increment of 0 still performs the full read-modify-write.
- Reset mid-operation: the in-flight update is discarded, no acknowledge is issued for it, and INIT restarts from address 0.

## Timing
- Zero-fill: 2^ADDR_WIDTH cycles after Reset deasserts (64 by default). Init_done rises in the cycle after the last write.
- Update cycle:
  - Grant is in IDLE (cycle t).
  - Reg_next and the read address are at t+1.
  - The sum is captured at t+2.
  - Wea=1 at t+3.
  - Back in IDLE at t+4, so the next grant can occur at t+4.
- Throughput: one update per 4 cycles.
- Back-to-back updates to the same address are hazard-free: the write at t+3 completes before the next read address is issued at t+5.
- Wea is high in exactly one cycle per update and never in IDLE, READ or WAIT.

## Test plan
- Reset, then idle for 70 cycles -> 64 writes of 0 to addresses 0..63 in consecutive cycles. Init_done=1 from cycle 65. Port B reads 0 at every address.
- After init, channel 0 requests addr 5, inc 3, twice -> RAM[5]=3, then 6. Reg_next_0 is one cycle wide, 4 cycles apart.
- Preload RAM[9]=32'hFFFF_FFFE; channel 1 requests addr 9, inc 5 -> RAM[9]=32'h0000_0003 (wrap).
- Both channels hold requests continuously, ch0 to addr 1 and ch1 to addr 2, inc 1 -> grants alternate 0,1,0,1. After 8 updates, RAM[1]=4 and RAM[2]=4.
- Assert Reset during the WAIT of an update to addr 7 -> no Reg_next, no write of the partial sum. Zero-fill restarts from addr 0 and RAM[7]=0 after init.
- Raise requests during INIT -> no acknowledge until Init_done=1. The first grant goes to channel 0 when both are pending.
